// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the pipeline datapath and its sequencing/hazard
// controller. The datapath side is the master; the controller is the slave.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  // Datapath status toward the controller
  logic             start_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic [4:0]       ex_rd_i;
  logic             ex_memread_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ack_i;

  // Controller decisions back to the datapath
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             pipe_en_o;
  logic [1:0]       state_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [CNT_W-1:0] freeze_cnt_o;

  modport master (
    output start_i, id_rs1_i, id_rs2_i, ex_rd_i, ex_memread_i,
           branch_taken_i, mem_req_i, mem_ack_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_en_o,
           state_o, err_o, stall_cnt_o, flush_cnt_o, freeze_cnt_o
  );

  modport slave (
    input  start_i, id_rs1_i, id_rs2_i, ex_rd_i, ex_memread_i,
           branch_taken_i, mem_req_i, mem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_en_o,
           state_o, err_o, stall_cnt_o, flush_cnt_o, freeze_cnt_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Sequencing and hazard controller for the 5-stage pipeline: run gating,
// load-use stall, taken-branch flush, memory-wait freeze with timeout,
// and saturating event counters.
module pipeline_ctrl #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pipeline_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic               err_q;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  logic run, freeze, load_use, stall, flush, timeout_hit;

  assign timeout_hit = (wait_cnt_q == WAIT_W'(TIMEOUT_CYC));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // State register
  // NOTE: clocked state uses non-blocking (<=) so every flop samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection; an outstanding memory access is never abandoned
  always_comb begin
    // NOTE: defaulting every comb output first rules out inferred latches.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (freeze)            state_d = ST_WAIT;
        else if (!bus.start_i) state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (bus.mem_ack_i)     state_d = bus.start_i ? ST_RUN : ST_IDLE;
        else if (timeout_hit)  state_d = ST_ERR;
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Hazard resolution and pipeline enables; priority freeze > stall > flush
  always_comb begin
    run      = (state_q == ST_RUN) || (state_q == ST_WAIT);
    freeze   = run && bus.mem_req_i && !bus.mem_ack_i;
    load_use = bus.ex_memread_i && (bus.ex_rd_i != 5'd0) &&
               ((bus.ex_rd_i == bus.id_rs1_i) || (bus.ex_rd_i == bus.id_rs2_i));
    stall    = run && !freeze && load_use;
    flush    = run && !freeze && !stall && bus.branch_taken_i;

    bus.pc_write_o    = run && !freeze && !stall;
    bus.ifid_write_o  = run && !freeze && !stall;
    bus.pipe_en_o     = run && !freeze;
    bus.idex_bubble_o = stall;
    bus.ifid_flush_o  = flush;
  end

  // Wait-cycle counter: 1 on entering WAIT, +1 per unacknowledged WAIT cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_RUN:  wait_cnt_q <= freeze ? WAIT_W'(1) : '0;
        ST_WAIT: begin
          if (bus.mem_ack_i)    wait_cnt_q <= '0;
          else if (!timeout_hit) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        end
        default: wait_cnt_q <= '0;
      endcase
    end
  end

  // Sticky timeout error, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      err_q <= 1'b0;
    else if ((state_q == ST_WAIT) && !bus.mem_ack_i && timeout_hit)
      err_q <= 1'b1;
  end

  // Saturating event counters; stall/flush/freeze are all 0 outside RUN/WAIT
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= sat_inc(stall_cnt_q, stall);
      flush_cnt_q  <= sat_inc(flush_cnt_q, flush);
      freeze_cnt_q <= sat_inc(freeze_cnt_q, freeze);
    end
  end

  assign bus.state_o      = state_q;
  assign bus.err_o        = err_q;
  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.flush_cnt_o  = flush_cnt_q;
  assign bus.freeze_cnt_o = freeze_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencing and hazard controller for the 5-stage pipelined CPU.
- Gates execution on start_i and generates per-stage write enables, load-use stall, branch flush and memory-wait freeze.
- Counts stall, flush and freeze cycles for the bench and performance reporting.
- Sits beside the ID stage and replaces the separate start, hazard and flush logic.

Parameters:
CNT_W, 32, width of each event counter (saturating)
TIMEOUT_CYC, 64, maximum number of WAIT cycles before entering ERR (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
start_i  in  1  run enable from top level
id_rs1_i  in  5  rs1 of instruction in ID
id_rs2_i  in  5  rs2 of instruction in ID
ex_rd_i  in  5  rd of instruction in EX
ex_memread_i  in  1  instruction in EX is a load
branch_taken_i  in  1  branch resolved taken in ID
mem_req_i  in  1  MEM stage issues a load or store this cycle
mem_ack_i  in  1  data memory completes the access this cycle
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID register write enable
ifid_flush_o  out  1  zero IF/ID on next edge
idex_bubble_o  out  1  insert NOP into ID/EX
pipe_en_o  out  1  enable for ID/EX, EX/MEM and MEM/WB registers and regfile write
state_o  out  2  FSM state: IDLE=0, RUN=1, WAIT=2, ERR=3
err_o  out  1  memory timeout, sticky
stall_cnt_o  out  CNT_W  load-use stall cycles
flush_cnt_o  out  CNT_W  flush cycles
freeze_cnt_o  out  CNT_W  memory-freeze cycles

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE; wait counter=0; all counters=0; err_o=0.
  - All enables 0; ifid_flush_o=0; idex_bubble_o=0.
- Derived signals (combinational, same cycle):
  - run = state is RUN or WAIT.
  - freeze = run & mem_req_i & ~mem_ack_i.
  - lu = ex_memread_i & (ex_rd_i!=0) & (ex_rd_i==id_rs1_i | ex_rd_i==id_rs2_i).
  - stall = run & ~freeze & lu.
  - flush = run & ~freeze & ~stall & branch_taken_i.
- Priority is freeze > stall > flush. A taken branch during a load-use stall is not flushed; ID re-resolves it the next cycle.
- Output equations:
  - pc_write_o = ifid_write_o = run & ~freeze & ~stall.
  - pipe_en_o = run & ~freeze.
  - idex_bubble_o = stall.
  - ifid_flush_o = flush.
- In IDLE and ERR all outputs above are 0.
- FSM transitions, evaluated on the rising edge:
  - IDLE -> RUN when start_i=1. The first PC update happens in the cycle after start_i is sampled.
  - RUN -> WAIT when freeze; wait counter loads 1.
  - RUN -> IDLE when start_i=0 and no freeze.
  - RUN with start_i=0 and freeze -> WAIT. The access is never abandoned.
  - WAIT with mem_ack_i=1 -> RUN if start_i=1, else IDLE; wait counter cleared.
  - WAIT with mem_ack_i=0 and wait counter==TIMEOUT_CYC -> ERR; err_o=1.
  - WAIT otherwise: wait counter +1.
  - ERR is held until reset.
- A same-cycle ack (mem_req_i & mem_ack_i in RUN) causes no freeze and no WAIT entry.
- Counters:
  - Registered; increment on the edge ending a cycle where stall, flush or freeze respectively is 1.
  - Saturate at all-ones; no wrap.
  - Hold in IDLE and ERR.
- Reset mid-WAIT: immediate return to IDLE; counters and err_o cleared.
- ex_rd_i==0 never stalls, even with ex_memread_i=1.

Test Plan:
- Reset with start_i=0 for 3 cycles -> state_o=0 and pc_write_o=0 throughout. Raise start_i -> state_o=1 next edge and pc_write_o=1.
- lw x5 in EX (ex_memread_i=1, ex_rd_i=5), id_rs2_i=5 -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for 1 cycle, stall_cnt_o 0->1. Repeat with ex_rd_i=0 -> no stall.
- branch_taken_i=1 alone -> ifid_flush_o=1 and flush_cnt_o=1. branch_taken_i=1 concurrent with lu -> flush 0, stall 1, flush_cnt_o unchanged.
- mem_req_i=1 with ack after 4 cycles -> pipe_en_o=0 for 4 cycles, state_o=2 during cycles 2-4, freeze_cnt_o=4, stall and flush suppressed while frozen even with lu=1.
- TIMEOUT_CYC=3, mem_req_i held and no ack -> ERR at edge 4, err_o=1, all enables 0. Ack afterwards -> stays ERR. rst_i pulse -> IDLE and counters 0.
- CNT_W=3, 9 consecutive stalls -> stall_cnt_o saturates at 7. start_i dropped mid-freeze -> WAIT, then IDLE on ack.
